// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg: shared types and defaults for the Booth multiply sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int c_WIDTH_DEFAULT = 32;
    localparam int c_CNT_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } booth_op_t;

    function automatic booth_op_t booth_op(input logic [1:0] pair);
        case (pair)
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_PASS;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_recode.sv
// ============================================================================
// booth_recode: radix-2 Booth recoding of P[1:0] into adder operand B / carry-in.
// Rev 1.0
// ============================================================================
`default_nettype none

module booth_recode
    import mult_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic [1:0]       i_p_low,
    input  logic [WIDTH-1:0] i_m,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_add_b,
    output logic             o_add_cin
);

    booth_op_t w_op;

    always_comb begin
        w_op      = OP_PASS;
        o_add_b   = '0;
        o_add_cin = 1'b0;
        if (i_en) begin
            w_op = booth_op(i_p_low);
        end
        case (w_op)
            OP_ADD: o_add_b = i_m;
            OP_SUB: begin
                o_add_b   = ~i_m;
                o_add_cin = 1'b1;
            end
            default: begin
                o_add_b   = '0;
                o_add_cin = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/booth_mult_ctrl.sv
// ============================================================================
// booth_mult_ctrl: radix-2 Booth signed multiply sequencer driving a shared
// external adder. Optional macro MULT_EXCEPTION_EN enables the overflow flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module booth_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2*WIDTH:0]   r_p;
    logic [WIDTH-1:0]   r_m;
    logic [CNT_W-1:0]   r_count;
    logic               w_run;
    logic               w_ovf;
    logic               w_sign;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_run          = 1'b0;
        data_resultRDY = 1'b0;
        busy           = 1'b0;
        case (r_state)
            IDLE: begin
                if (ctrl_MULT) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                busy  = 1'b1;
                if (r_count == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                data_resultRDY = 1'b1;
                busy           = 1'b1;
                w_state_nxt    = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The adder is released to the ALU whenever no iteration is in progress.
    assign add_a = w_run ? r_p[2*WIDTH:WIDTH+1] : '0;

    booth_recode #(
        .WIDTH (WIDTH)
    ) u_recode (
        .i_p_low   (r_p[1:0]),
        .i_m       (r_m),
        .i_en      (w_run),
        .o_add_b   (add_b),
        .o_add_cin (add_cin)
    );

    // Recovering the true sign lets M = -2**(WIDTH-1) work on a WIDTH-bit adder.
    assign w_ovf  = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != add_a[WIDTH-1]);
    assign w_sign = add_sum[WIDTH-1] ^ w_ovf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_p     <= '0;
            r_m     <= '0;
            r_count <= '0;
        end else if (r_state == IDLE && ctrl_MULT) begin
            r_m     <= data_operandA;
            r_p     <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            r_count <= '0;
        end else if (w_run) begin
            r_p     <= {w_sign, add_sum, r_p[WIDTH:1]};
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign data_result = r_p[WIDTH:1];

`ifdef MULT_EXCEPTION_EN
    assign data_exception = ~((&r_p[2*WIDTH:WIDTH]) | ~(|r_p[2*WIDTH:WIDTH]));
`else
    assign data_exception = 1'b0;
`endif

endmodule

`default_nettype wire
